// File: rtl/fir_ctrl_pkg.sv
// Shared types and default widths for the FIR sample sequencer.
package fir_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam int unsigned DEF_X_W = 3;
   localparam int unsigned DEF_Y_W = 12;
   localparam int unsigned CNT_W   = 16;

endpackage

// File: rtl/fir_sample_fifo.sv
// Synchronous FIFO holding input samples until the sequencer issues them.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module fir_sample_fifo #(
   parameter int unsigned W     = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign o_full  = (count_q == CW'(DEPTH));
   assign o_empty = (count_q == '0);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;
   assign o_data  = mem_q[rd_ptr_q];

   // NOTE: storage is deliberately not reset; an empty count makes stale entries unreachable.
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/fir_sample_sequencer.sv
// Single-clock sample sequencer for the FIR core: buffers samples, pulses the
// core enable once per trigger, waits the core latency and hands off the result.
module fir_sample_sequencer
   import fir_ctrl_pkg::*;
#(
   parameter int unsigned F_CLK      = 50_000_000,
   parameter int unsigned SAMPLE_HZ  = 1000,
   parameter int unsigned CORE_LAT   = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned X_W        = DEF_X_W,
   parameter int unsigned Y_W        = DEF_Y_W
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_mode,
   input  logic             i_step,
   input  logic             i_x_valid,
   input  logic [X_W-1:0]   i_x_data,
   output logic             o_x_ready,
   output logic             o_core_en,
   output logic [X_W-1:0]   o_core_x,
   input  logic [Y_W-1:0]   i_core_y,
   output logic             o_y_valid,
   output logic [Y_W-1:0]   o_y_data,
   input  logic             i_y_ready,
   output logic             o_busy,
   output logic             o_underrun,
   output logic             o_overrun,
   output logic [CNT_W-1:0] o_sample_cnt
);

   localparam int unsigned DIV_TC = F_CLK / SAMPLE_HZ - 1;
   localparam int unsigned DIV_W  = (DIV_TC > 1) ? $clog2(DIV_TC + 1) : 1;
   localparam int unsigned LAT_W  = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_TC);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(CORE_LAT - 1);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [LAT_W-1:0] wait_q, wait_d;
   logic [X_W-1:0]   core_x_q, core_x_d;
   logic [Y_W-1:0]   y_data_q, y_data_d;
   logic             under_q, under_d;
   logic             over_q, over_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick;
   logic             trigger;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [X_W-1:0]   fifo_data;

   assign fifo_push = i_x_valid && !fifo_full;

   fir_sample_fifo #(
      .W     (X_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (fifo_push),
      .i_data  (i_x_data),
      .i_pop   (fifo_pop),
      .o_data  (fifo_data),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   // Sample-rate divider; held at zero in step mode so auto mode always starts a full period.
   always_comb begin
      tick  = i_mode && (div_q == DIV_LAST);
      div_d = div_q + 1'b1;
      if (!i_mode || tick) div_d = '0;
   end

   assign trigger = i_mode ? tick : i_step;

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      core_x_d = core_x_q;
      y_data_d = y_data_q;
      under_d  = under_q;
      over_d   = over_q;
      cnt_d    = cnt_q;
      fifo_pop = 1'b0;

      if (trigger && (state_q != ST_IDLE)) over_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (trigger) begin
               if (fifo_empty) begin
                  under_d = 1'b1;
               end else begin
                  fifo_pop = 1'b1;
                  core_x_d = fifo_data;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = cnt_q + 1'b1;
            wait_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_q == LAT_LAST) begin
               y_data_d = i_core_y;
               state_d  = ST_HOLD;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (i_y_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         div_q    <= '0;
         wait_q   <= '0;
         core_x_q <= '0;
         y_data_q <= '0;
         under_q  <= 1'b0;
         over_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         wait_q   <= wait_d;
         core_x_q <= core_x_d;
         y_data_q <= y_data_d;
         under_q  <= under_d;
         over_q   <= over_d;
         cnt_q    <= cnt_d;
      end
   end

   // Enable and valid are decoded from the state flop, so reset clears them asynchronously.
   assign o_core_en    = (state_q == ST_ISSUE);
   assign o_y_valid    = (state_q == ST_HOLD);
   assign o_busy       = (state_q != ST_IDLE);
   assign o_x_ready    = !fifo_full;
   assign o_core_x     = core_x_q;
   assign o_y_data     = y_data_q;
   assign o_underrun   = under_q;
   assign o_overrun    = over_q;
   assign o_sample_cnt = cnt_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Self-checking bench: a transaction-level model tracks the sequencer cycle by
// cycle, with directed scenarios adding hand-computed expectations.
module tb_fir_sample_sequencer;

   localparam int F_CLK     = 100;
   localparam int SAMPLE_HZ = 10;
   localparam int LAT       = 1;
   localparam int DEPTH     = 4;
   localparam int XW        = 3;
   localparam int YW        = 12;
   localparam int PERIOD    = F_CLK / SAMPLE_HZ;

   logic          i_clk     = 1'b0;
   logic          i_rst_n   = 1'b0;
   logic          i_mode    = 1'b0;
   logic          i_step    = 1'b0;
   logic          i_x_valid = 1'b0;
   logic [XW-1:0] i_x_data  = '0;
   logic [YW-1:0] i_core_y  = '0;
   logic          i_y_ready = 1'b1;
   logic          o_x_ready;
   logic          o_core_en;
   logic [XW-1:0] o_core_x;
   logic          o_y_valid;
   logic [YW-1:0] o_y_data;
   logic          o_busy;
   logic          o_underrun;
   logic          o_overrun;
   logic [15:0]   o_sample_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   fir_sample_sequencer #(
      .F_CLK      (F_CLK),
      .SAMPLE_HZ  (SAMPLE_HZ),
      .CORE_LAT   (LAT),
      .FIFO_DEPTH (DEPTH),
      .X_W        (XW),
      .Y_W        (YW)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_mode       (i_mode),
      .i_step       (i_step),
      .i_x_valid    (i_x_valid),
      .i_x_data     (i_x_data),
      .o_x_ready    (o_x_ready),
      .o_core_en    (o_core_en),
      .o_core_x     (o_core_x),
      .i_core_y     (i_core_y),
      .o_y_valid    (o_y_valid),
      .o_y_data     (o_y_data),
      .i_y_ready    (i_y_ready),
      .o_busy       (o_busy),
      .o_underrun   (o_underrun),
      .o_overrun    (o_overrun),
      .o_sample_cnt (o_sample_cnt)
   );

   initial forever #5 i_clk = ~i_clk;

   // Core output changes every cycle, so a capture on the wrong cycle is visible.
   initial forever begin
      @(posedge i_clk);
      #1;
      i_core_y = YW'($urandom);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int            xq[$];
   logic [XW-1:0] m_core_x;
   logic [YW-1:0] m_y;
   logic [15:0]   m_cnt;
   bit            m_under, m_over, m_active;
   int            m_t0, m_n, m_auto_age;

   task automatic model_reset();
      xq.delete();
      m_core_x   = '0;
      m_y        = '0;
      m_cnt      = '0;
      m_under    = 1'b0;
      m_over     = 1'b0;
      m_active   = 1'b0;
      m_t0       = 0;
      m_n        = 0;
      m_auto_age = 0;
   endtask

   task automatic model_compare();
      int phase;
      phase = m_n - m_t0;
      check("m_core_en",    o_core_en,    32'(m_active && phase == 1));
      check("m_y_valid",    o_y_valid,    32'(m_active && phase >= 2 + LAT));
      check("m_busy",       o_busy,       32'(m_active));
      check("m_x_ready",    o_x_ready,    32'(xq.size() < DEPTH));
      check("m_core_x",     o_core_x,     32'(m_core_x));
      check("m_y_data",     o_y_data,     32'(m_y));
      check("m_underrun",   o_underrun,   32'(m_under));
      check("m_overrun",    o_overrun,    32'(m_over));
      check("m_sample_cnt", o_sample_cnt, 32'(m_cnt));
   endtask

   task automatic model_advance();
      int  phase, sz;
      bit  tick, trig, accept;
      phase = m_n - m_t0;
      if (m_active && phase == 1)       m_cnt++;
      if (m_active && phase == 1 + LAT) m_y = i_core_y;
      tick = 1'b0;
      if (i_mode) begin
         tick = ((m_auto_age % PERIOD) == PERIOD - 1);
         m_auto_age++;
      end else begin
         m_auto_age = 0;
      end
      trig   = i_mode ? tick : i_step;
      sz     = xq.size();
      accept = trig && !m_active;
      if (trig && m_active) m_over = 1'b1;
      if (accept) begin
         if (sz > 0) m_core_x = XW'(xq.pop_front());
         else        m_under  = 1'b1;
      end
      if (i_x_valid && sz < DEPTH) xq.push_back(int'(i_x_data));
      if (m_active && phase >= 2 + LAT && i_y_ready) m_active = 1'b0;
      if (accept) begin
         m_active = 1'b1;
         m_t0     = m_n;
      end
      m_n++;
   endtask

   always @(negedge i_clk) begin
      if (!i_rst_n) model_reset();
      model_compare();
      if (i_rst_n) model_advance();
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic push(input int v);
      i_x_valid = 1'b1;
      i_x_data  = XW'(v);
      cyc(1);
      i_x_valid = 1'b0;
   endtask

   task automatic step();
      i_step = 1'b1;
      cyc(1);
      i_step = 1'b0;
   endtask

   task automatic wait_en(output int k);
      k = 0;
      do begin
         @(posedge i_clk);
         k++;
         @(negedge i_clk);
      end while (!o_core_en && k < 4 * PERIOD);
   endtask

   int            seq1[3] = '{3, 5, 1};
   int            en_cnt;
   int            k;
   bit            stable;
   logic [YW-1:0] held_y;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cyc(3);
      check("rst_x_ready", o_x_ready, 1);
      check("rst_busy",    o_busy,    0);
      check("rst_cnt",     o_sample_cnt, 0);
      i_rst_n = 1'b1;
      cyc(2);

      // Three samples issued in order, one step each.
      push(3); push(5); push(1);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge i_clk);
         check("t1_core_en_T1", o_core_en, 1);
         check("t1_core_x",     o_core_x,  32'(seq1[i]));
         @(negedge i_clk);
         check("t1_core_en_T2", o_core_en, 0);
         @(negedge i_clk);
         check("t1_y_valid_T3", o_y_valid, 1);
         cyc(7);
      end
      check("t1_sample_cnt", o_sample_cnt, 3);

      // Fill the buffer with valid held high; the fifth sample is held off.
      i_x_valid = 1'b1;
      for (int v = 1; v <= 4; v++) begin
         i_x_data = XW'(v);
         cyc(1);
      end
      check("t2_full_after4", o_x_ready, 0);
      i_x_data = XW'(5);
      cyc(1);
      check("t2_still_full", o_x_ready, 0);
      i_x_valid = 1'b0;
      step();
      check("t2_ready_after_pop", o_x_ready, 1);
      check("t2_pop_value",       o_core_x,  1);
      cyc(9);
      for (int i = 0; i < 3; i++) begin
         step();
         cyc(9);
      end
      check("t2_last_value", o_core_x, 4);

      // Trigger with empty buffer.
      step();
      @(negedge i_clk);
      check("t3_core_en", o_core_en,  1);
      check("t3_core_x",  o_core_x,   4);
      check("t3_under",   o_underrun, 1);
      @(negedge i_clk);
      @(negedge i_clk);
      check("t3_y_valid", o_y_valid, 1);
      cyc(7);

      // Output back-pressure with an overlapping second step.
      push(6);
      i_y_ready = 1'b0;
      step();
      en_cnt = 0;
      stable = 1'b1;
      held_y = '0;
      for (int j = 0; j < 23; j++) begin
         i_step = (j == 7);
         @(negedge i_clk);
         if (o_core_en) en_cnt++;
         if (j == 2) held_y = o_y_data;
         if (j >= 2 && (!o_y_valid || o_y_data !== held_y)) stable = 1'b0;
         @(posedge i_clk);
         #1;
      end
      i_step = 1'b0;
      check("t4_core_x",    o_core_x,  6);
      check("t4_y_stable",  stable,    1);
      check("t4_one_en",    en_cnt,    1);
      check("t4_overrun",   o_overrun, 1);
      i_y_ready = 1'b1;
      cyc(1);
      check("t4_released", o_busy, 0);
      cyc(3);

      // Auto mode: pulse every PERIOD cycles, stops in step mode, restarts from zero.
      i_mode = 1'b1;
      wait_en(k);
      check("t5_first_tick", k, PERIOD);
      wait_en(k);
      check("t5_period_a", k, PERIOD);
      wait_en(k);
      check("t5_period_b", k, PERIOD);
      cyc(4);
      i_mode = 1'b0;
      en_cnt = 0;
      for (int j = 0; j < 30; j++) begin
         @(negedge i_clk);
         if (o_core_en) en_cnt++;
      end
      check("t5_step_quiet", en_cnt, 0);
      cyc(1);
      i_mode = 1'b1;
      wait_en(k);
      check("t5_restart_from0", k, PERIOD);
      cyc(1);
      i_mode = 1'b0;
      cyc(6);

      // Randomised traffic: step mode, then auto mode.
      for (int i = 0; i < 400; i++) begin
         i_mode    = (i >= 200);
         i_step    = ($urandom_range(0, 3) == 0);
         i_x_valid = 1'($urandom_range(0, 1));
         i_x_data  = XW'($urandom);
         i_y_ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      i_mode = 1'b0; i_step = 1'b0; i_x_valid = 1'b0; i_y_ready = 1'b1;
      cyc(10);

      // Reset during WAIT.
      push(2);
      step();
      @(posedge i_clk);
      #2;
      check("t6_in_wait", o_busy, 1);
      i_rst_n = 1'b0;
      #1;
      check("t6_core_en", o_core_en,    0);
      check("t6_busy",    o_busy,       0);
      check("t6_y_valid", o_y_valid,    0);
      check("t6_core_x",  o_core_x,     0);
      check("t6_y_data",  o_y_data,     0);
      check("t6_flags",   {o_underrun, o_overrun}, 0);
      check("t6_cnt",     o_sample_cnt, 0);
      check("t6_x_ready", o_x_ready,    1);
      cyc(2);
      i_rst_n = 1'b1;
      cyc(1);
      push(7);
      step();
      @(negedge i_clk);
      check("t6_post_en",    o_core_en, 1);
      check("t6_post_x",     o_core_x,  7);
      @(negedge i_clk);
      check("t6_post_cnt",   o_sample_cnt, 1);
      check("t6_post_under", o_underrun,   0);
      cyc(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
